// File: rtl/fighter_pkg.sv
// fighter_pkg: shared constants, winner encodings and FSM states for the blood bar
package fighter_pkg;
  localparam logic [3:0] HEALTH_MAX = 4'd10;
  localparam int SPRITE_DIM = 64;
  localparam logic [11:0] TRANSPARENT = 12'h000;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1 = 2'b01;
  localparam logic [1:0] WIN_P2 = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;
  typedef enum logic {FIGHT, KO} state_t;
endpackage

// File: rtl/health_track.sv
// health_track: per-player saturating health, frame-latched display value, blink counter and zero detect
module health_track import fighter_pkg::*; #(
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       dmg,
  input  logic       frame_tick,
  output logic [3:0] health,
  output logic [3:0] disp,
  output logic       blinking,
  output logic       zero_hit
);
  logic [3:0] health_q, health_d, disp_q, disp_d;
  logic [5:0] blink_q, blink_d;
  // next health, display latch and blink count; a fresh hit reloads the blink count
  always_comb begin
    health_d = clr ? HEALTH_MAX : (dmg && health_q != 4'd0) ? health_q - 4'd1 : health_q;
    disp_d = clr ? HEALTH_MAX : frame_tick ? health_q : disp_q;
    blink_d = clr ? 6'd0 : dmg ? 6'(BLINK_FRAMES) : (frame_tick && blink_q != 6'd0) ? blink_q - 6'd1 : blink_q;
  end
  // player state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      health_q <= HEALTH_MAX;
      disp_q <= HEALTH_MAX;
      blink_q <= 6'd0;
    end else begin
      health_q <= health_d;
      disp_q <= disp_d;
      blink_q <= blink_d;
    end
  end
  assign health = health_q;
  assign disp = disp_q;
  assign blinking = blink_q != 6'd0;
  assign zero_hit = dmg && health_q == 4'd1;
endmodule

// File: rtl/blood_bar_ctrl.sv
// blood_bar_ctrl: round FSM, sprite hit test, blood ROM addressing and latency-aligned pixel output
module blood_bar_ctrl import fighter_pkg::*; #(
  parameter int P1_X = 32,
  parameter int P1_Y = 16,
  parameter int P2_X = 544,
  parameter int P2_Y = 16,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        p1_dmg,
  input  logic        p2_dmg,
  input  logic        round_reset,
  output logic [5:0]  rom_row,
  output logic [5:0]  rom_col,
  output logic [3:0]  rom_sel,
  input  logic [11:0] rom_color,
  output logic        blood_on,
  output logic [11:0] blood_rgb,
  output logic [3:0]  p1_health,
  output logic [3:0]  p2_health,
  output logic        ko,
  output logic [1:0]  winner
);
  state_t state_q, state_d;
  logic ko_q, ko_d;
  logic [1:0] winner_q, winner_d;
  logic [2:0] frame_cnt_q, frame_cnt_d;
  logic acc1, acc2, z1, z2, blink1, blink2;
  logic [3:0] disp1, disp2;
  logic in1, in2, hit_d, hit_q, hidden_d, hidden_q, blood_on_d, blood_on_q;
  logic [3:0] rom_sel_d, rom_sel_q;
  logic [11:0] blood_rgb_d, blood_rgb_q;
  assign acc1 = p1_dmg && state_q == FIGHT && !round_reset;
  assign acc2 = p2_dmg && state_q == FIGHT && !round_reset;
  health_track #(.BLINK_FRAMES(BLINK_FRAMES)) u_p1 (
    .clk(clk), .reset(reset), .clr(round_reset), .dmg(acc1), .frame_tick(frame_tick),
    .health(p1_health), .disp(disp1), .blinking(blink1), .zero_hit(z1)
  );
  health_track #(.BLINK_FRAMES(BLINK_FRAMES)) u_p2 (
    .clk(clk), .reset(reset), .clr(round_reset), .dmg(acc2), .frame_tick(frame_tick),
    .health(p2_health), .disp(disp2), .blinking(blink2), .zero_hit(z2)
  );
  // round FSM: a decrement to zero ends the fight, round_reset always restarts it
  always_comb begin
    state_d = state_q;
    winner_d = winner_q;
    ko_d = 1'b0;
    frame_cnt_d = frame_cnt_q + {2'b00, frame_tick};
    if (round_reset) begin
      state_d = FIGHT;
      winner_d = WIN_NONE;
    end else if (state_q == FIGHT && (z1 || z2)) begin
      state_d = KO;
      ko_d = 1'b1;
      winner_d = (z1 && z2) ? WIN_DRAW : z1 ? WIN_P2 : WIN_P1;
    end
  end
  // FSM and frame counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FIGHT;
      winner_q <= WIN_NONE;
      ko_q <= 1'b0;
      frame_cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      winner_q <= winner_d;
      ko_q <= ko_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  // hit test and ROM addressing this cycle; output stage uses the ROM colour returned a cycle later
  always_comb begin
    in1 = video_on && x >= 10'(P1_X) && {1'b0, x} < 11'(P1_X + SPRITE_DIM)
          && y >= 10'(P1_Y) && {1'b0, y} < 11'(P1_Y + SPRITE_DIM);
    in2 = video_on && x >= 10'(P2_X) && {1'b0, x} < 11'(P2_X + SPRITE_DIM)
          && y >= 10'(P2_Y) && {1'b0, y} < 11'(P2_Y + SPRITE_DIM);
    rom_row = in1 ? 6'(y - 10'(P1_Y)) : in2 ? 6'(y - 10'(P2_Y)) : 6'd0;
    rom_col = in1 ? 6'(x - 10'(P1_X)) : in2 ? 6'(x - 10'(P2_X)) : 6'd0;
    hit_d = in1 || in2;
    hidden_d = frame_cnt_q[2] && (in1 ? blink1 : blink2);
    rom_sel_d = in1 ? disp1 : in2 ? disp2 : 4'd0;
    blood_on_d = hit_q && !hidden_q && rom_color != TRANSPARENT;
    blood_rgb_d = blood_on_d ? rom_color : TRANSPARENT;
  end
  // two-stage pixel pipeline matching the ROM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
      hidden_q <= 1'b0;
      rom_sel_q <= 4'd0;
      blood_on_q <= 1'b0;
      blood_rgb_q <= TRANSPARENT;
    end else begin
      hit_q <= hit_d;
      hidden_q <= hidden_d;
      rom_sel_q <= rom_sel_d;
      blood_on_q <= blood_on_d;
      blood_rgb_q <= blood_rgb_d;
    end
  end
  assign rom_sel = rom_sel_q;
  assign blood_on = blood_on_q;
  assign blood_rgb = blood_rgb_q;
  assign ko = ko_q;
  assign winner = winner_q;
endmodule

// File: tb/tb_blood_bar_ctrl.sv
// tb_blood_bar_ctrl: scoreboard bench with a behavioural fighter model and randomized pixels/damage
module tb_blood_bar_ctrl;
  localparam int P1X = 32, P1Y = 16, P2X = 544, P2Y = 16, BF = 32;
  logic clk = 0, reset = 1, video_on = 0, frame_tick = 0, p1_dmg = 0, p2_dmg = 0, round_reset = 0;
  logic [9:0] x = 0, y = 0;
  logic [11:0] rom_color = 0;
  logic [5:0] rom_row, rom_col;
  logic [3:0] rom_sel, p1_health, p2_health;
  logic blood_on, ko;
  logic [11:0] blood_rgb;
  logic [1:0] winner;
  always #5 clk = ~clk;
  blood_bar_ctrl #(.P1_X(P1X), .P1_Y(P1Y), .P2_X(P2X), .P2_Y(P2Y), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .frame_tick(frame_tick),
    .p1_dmg(p1_dmg), .p2_dmg(p2_dmg), .round_reset(round_reset), .rom_row(rom_row),
    .rom_col(rom_col), .rom_sel(rom_sel), .rom_color(rom_color), .blood_on(blood_on),
    .blood_rgb(blood_rgb), .p1_health(p1_health), .p2_health(p2_health), .ko(ko), .winner(winner)
  );
  typedef struct {int kind; int due; logic [11:0] val;} ent_t;
  ent_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  bit done = 0, closed = 0;
  string names[9] = '{"blood_on", "blood_rgb", "rom_sel", "rom_row", "rom_col", "p1_health", "p2_health", "ko", "winner"};
  int h[2], disp[2], blink[2], fcnt = 0, win = 0;
  bit kod = 0;
  logic [11:0] pend_col = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [11:0] actual(int k);
    case (k)
      0: return {11'd0, blood_on};
      1: return blood_rgb;
      2: return {8'd0, rom_sel};
      3: return {6'd0, rom_row};
      4: return {6'd0, rom_col};
      5: return {8'd0, p1_health};
      6: return {8'd0, p2_health};
      7: return {11'd0, ko};
      default: return {10'd0, winner};
    endcase
  endfunction
  always @(negedge clk) begin : monitor
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        checks++;
        if (sb[i].due < cyc || actual(sb[i].kind) !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d got %0h want %0h", names[sb[i].kind], cyc, actual(sb[i].kind), sb[i].val);
        end
        sb.delete(i);
      end else i++;
    end
    if (done && !closed) begin
      closed = 1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain got %0d pending want 0", sb.size());
      end
    end
  end
  task automatic push(int k, int d, int v);
    sb.push_back('{k, d, 12'(v)});
  endtask
  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      h[p] = 10;
      disp[p] = 10;
      blink[p] = 0;
    end
    kod = 0;
    win = 0;
  endtask
  task automatic step(int px, int py, bit von, bit ft, bit d1, bit d2, bit rr, bit rs, logic [11:0] col);
    int c, row, cl, sel;
    bit in1, in2, hid, on, a1, a2, z1, z2, kop;
    c = cyc;
    x = 10'(px); y = 10'(py); video_on = von; frame_tick = ft;
    p1_dmg = d1; p2_dmg = d2; round_reset = rr; reset = rs;
    rom_color = pend_col;
    pend_col = col;
    in1 = von && px >= P1X && px < P1X + 64 && py >= P1Y && py < P1Y + 64;
    in2 = von && px >= P2X && px < P2X + 64 && py >= P2Y && py < P2Y + 64;
    row = in1 ? py - P1Y : in2 ? py - P2Y : 0;
    cl = in1 ? px - P1X : in2 ? px - P2X : 0;
    sel = in1 ? disp[0] : in2 ? disp[1] : 0;
    hid = fcnt >= 4 && (in1 ? blink[0] > 0 : blink[1] > 0);
    on = (in1 || in2) && !hid && col != 0;
    kop = 0;
    push(3, c, row);
    push(4, c, cl);
    if (rs) begin
      foreach (sb[i]) if (sb[i].due == c + 1 && sb[i].kind <= 1) sb[i].val = 0;
      model_reset();
      fcnt = 0;
      push(2, c + 1, 0);
      push(0, c + 2, 0);
      push(1, c + 2, 0);
    end else begin
      push(2, c + 1, sel);
      push(0, c + 2, on);
      push(1, c + 2, on ? col : 0);
      if (rr) model_reset();
      else begin
        a1 = d1 && !kod;
        a2 = d2 && !kod;
        z1 = a1 && h[0] == 1;
        z2 = a2 && h[1] == 1;
        if (ft) for (int p = 0; p < 2; p++) begin
          disp[p] = h[p];
          if (blink[p] > 0) blink[p]--;
        end
        if (a1) begin if (h[0] > 0) h[0]--; blink[0] = BF; end
        if (a2) begin if (h[1] > 0) h[1]--; blink[1] = BF; end
        if (z1 || z2) begin
          kod = 1;
          kop = 1;
          win = (z1 && z2) ? 3 : z1 ? 2 : 1;
        end
      end
      if (ft) fcnt = (fcnt + 1) % 8;
    end
    push(5, c + 1, h[0]);
    push(6, c + 1, h[1]);
    push(7, c + 1, kop);
    push(8, c + 1, win);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 12'h000);
  endtask
  initial begin
    int c, px, py;
    model_reset();
    @(posedge clk);
    #1;
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 12'h000);
    c = cyc;
    push(0, c, 0); push(1, c, 0); push(2, c, 0); push(7, c, 0); push(8, c, 0);
    idle();
    c = cyc;
    push(3, c, 3); push(4, c, 5); push(2, c + 1, 10); push(0, c + 2, 1); push(1, c + 2, 12'hF00);
    step(P1X + 5, P1Y + 3, 1, 0, 0, 0, 0, 0, 12'hF00);
    idle(); idle();
    repeat (3) step(0, 0, 0, 0, 1, 0, 0, 0, 12'h000);
    c = cyc;
    push(5, c, 7); push(2, c + 1, 10);
    step(P1X + 8, P1Y + 14, 1, 0, 0, 0, 0, 0, 12'h0F0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 12'h000);
    c = cyc;
    push(2, c + 1, 7);
    step(P1X + 8, P1Y + 14, 1, 0, 0, 0, 0, 0, 12'h0F0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 12'h000);
    c = cyc;
    push(5, c + 1, 9); push(6, c + 1, 9);
    step(0, 0, 0, 0, 1, 1, 0, 0, 12'h000);
    repeat (8) step(0, 0, 0, 0, 1, 1, 0, 0, 12'h000);
    c = cyc;
    push(7, c + 1, 1); push(8, c + 1, 3); push(5, c + 1, 0); push(6, c + 1, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 12'h000);
    c = cyc;
    push(7, c + 1, 0); push(8, c + 1, 3); push(5, c + 1, 0); push(6, c + 1, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 12'h000);
    c = cyc;
    push(5, c + 1, 10); push(6, c + 1, 10); push(8, c + 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 12'h000);
    c = cyc;
    push(5, c + 1, 9);
    step(0, 0, 0, 0, 1, 0, 0, 0, 12'h000);
    c = cyc;
    push(0, c + 2, 0); push(1, c + 2, 0);
    step(P2X + 16, P2Y + 24, 1, 0, 0, 0, 0, 0, 12'h000);
    c = cyc;
    push(0, c + 2, 0);
    step(P2X + 16, P2Y + 24, 0, 0, 0, 0, 0, 0, 12'hF00);
    step(0, 0, 0, 0, 0, 0, 1, 0, 12'h000);
    step(0, 0, 0, 0, 0, 1, 0, 0, 12'h000);
    for (int f = 0; f < 40; f++) begin
      step(0, 0, 0, 1, 0, 0, 0, 0, 12'h000);
      repeat (3) step(P2X + $urandom_range(0, 63), P2Y + $urandom_range(0, 63), 1, 0, 0, 0, 0, 0, 12'($urandom_range(1, 4095)));
    end
    c = cyc;
    push(0, c + 2, 1); push(1, c + 2, 12'h0F0);
    step(P2X + 1, P2Y + 1, 1, 0, 0, 0, 0, 0, 12'h0F0);
    step(P1X + 2, P1Y + 2, 1, 0, 0, 0, 0, 0, 12'h00F);
    step(P1X + 3, P1Y + 2, 1, 0, 0, 0, 0, 1, 12'h00F);
    step(P1X + 4, P1Y + 2, 1, 0, 0, 0, 0, 0, 12'h00F);
    step(P1X + 5, P1Y + 2, 1, 0, 0, 0, 0, 0, 12'h00F);
    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 2))
        0: px = P1X - 4 + $urandom_range(0, 72);
        1: px = P2X - 4 + $urandom_range(0, 72);
        default: px = $urandom_range(0, 639);
      endcase
      py = $urandom_range(0, 90);
      step(px, py, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 149) == 0, $urandom_range(0, 999) == 0,
           $urandom_range(0, 3) == 0 ? 12'h000 : 12'($urandom_range(1, 4095)));
    end
    repeat (4) idle();
    repeat (3) @(posedge clk);
    done = 1;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
